test_pattern_gen: RTL and testbench

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

---
 rtl/test_pattern_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_test_pattern_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
// -----------------------------------------------------------------------------
// test_pattern_gen
//   Video test pattern source for an HDMI pipeline. Generates FLAT, colour
//   BARS, CHECKER and scrolling luma RAMP patterns in YCbCr.
//
//   Commands arrive on a one-cycle strobe and are held in a shadow set. At
//   every frame boundary the valid shadow fields are copied into the active
//   set, so each picture is drawn with one consistent configuration.
//
// Parameters
//   BAR_SHIFT    log2 of the colour bar width in pixels
//   CHECK_SHIFT  log2 of the checker square size in pixels/lines
//
// Ports
//   clk             pixel clock (sole clock)
//   rst_n           asynchronous active-low reset
//   de              active-video flag
//   pixel, line     absolute pixel / line index (12 bit)
//   frame_end       one-cycle frame boundary pulse
//   command_strobe  one-cycle command valid
//   command         18-bit command word {opcode[1:0], payload[15:0]}
//   Cb, Y, Cr       registered colour outputs, one clk after de/pixel/line
//   cmd_pending     a shadowed command is waiting for the next frame_end
// -----------------------------------------------------------------------------
module test_pattern_gen #(
    parameter int BAR_SHIFT   = 7,
    parameter int CHECK_SHIFT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de,
    input  logic [11:0] pixel,
    input  logic [11:0] line,
    input  logic        frame_end,
    input  logic        command_strobe,
    input  logic [17:0] command,
    output logic [7:0]  Cb,
    output logic [7:0]  Y,
    output logic [7:0]  Cr,
    output logic        cmd_pending
);

    typedef enum logic [1:0] {
        MODE_FLAT    = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_RAMP    = 2'd3
    } mode_e;

    // Bit positions of the per-field write strobes and pending flags
    localparam int F_MODE  = 0;
    localparam int F_CB    = 1;
    localparam int F_Y     = 2;
    localparam int F_CR    = 3;
    localparam int F_SPEED = 4;

    localparam logic [7:0] BLANK_Y = 8'd16;
    localparam logic [7:0] BLANK_C = 8'd128;

    // Colour bar lookup, returns {Y, Cb, Cr}
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = {8'd235, 8'd128, 8'd128};
            3'd1:    c = {8'd210, 8'd16,  8'd146};
            3'd2:    c = {8'd170, 8'd166, 8'd16 };
            3'd3:    c = {8'd145, 8'd54,  8'd34 };
            3'd4:    c = {8'd106, 8'd202, 8'd222};
            3'd5:    c = {8'd81,  8'd90,  8'd240};
            3'd6:    c = {8'd41,  8'd240, 8'd110};
            3'd7:    c = {8'd16,  8'd128, 8'd128};
            default: c = {8'd16,  8'd128, 8'd128};
        endcase
        return c;
    endfunction

    // Shadow (pending) set
    mode_e       pend_mode_r;
    logic [7:0]  pend_cb_r;
    logic [7:0]  pend_y_r;
    logic [7:0]  pend_cr_r;
    logic [3:0]  pend_speed_r;
    logic [4:0]  pend_v_r;
    logic [4:0]  pend_v_s;

    // Active set
    mode_e       mode_r;
    logic [7:0]  cb_r;
    logic [7:0]  y_r;
    logic [7:0]  cr_r;
    logic [3:0]  speed_r;
    logic [7:0]  offset_r;

    // Decode / colour datapath
    logic [4:0]  wr_s;
    logic [7:0]  y_s;
    logic [7:0]  cb_s;
    logic [7:0]  cr_s;
    logic [23:0] bar_s;

    // Output registers
    logic [7:0]  y_out_r;
    logic [7:0]  cb_out_r;
    logic [7:0]  cr_out_r;
    logic        cmd_pending_r;

    // Payload bits that no opcode looks at
    logic        unused_bits_s;
    assign unused_bits_s = ^{command[15:10], pixel, line};

    // Command decode: one write strobe per shadow field; reserved opcode and channel 3 write nothing
    always_comb begin
        wr_s = 5'b00000;
        if (command_strobe) begin
            case (command[17:16])
                2'b00: wr_s[F_MODE] = 1'b1;
                2'b01: begin
                    case (command[9:8])
                        2'b00:   wr_s[F_CB] = 1'b1;
                        2'b01:   wr_s[F_Y]  = 1'b1;
                        2'b10:   wr_s[F_CR] = 1'b1;
                        default: wr_s       = 5'b00000;
                    endcase
                end
                2'b10:   wr_s[F_SPEED] = 1'b1;
                default: wr_s          = 5'b00000;
            endcase
        end else begin
            wr_s = 5'b00000;
        end
    end

    // Next pending flags: frame_end clears, but a command in the same cycle waits for the next boundary
    always_comb begin
        pend_v_s = pend_v_r;
        if (frame_end) begin
            pend_v_s = wr_s;
        end else begin
            pend_v_s = pend_v_r | wr_s;
        end
    end

    // Shadow register data and valid flags; the last write within a frame wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_mode_r  <= MODE_FLAT;
            pend_cb_r    <= 8'd0;
            pend_y_r     <= 8'd0;
            pend_cr_r    <= 8'd0;
            pend_speed_r <= 4'd0;
            pend_v_r     <= 5'b00000;
        end else begin
            pend_v_r <= pend_v_s;
            if (wr_s[F_MODE])  pend_mode_r  <= mode_e'(command[1:0]);
            if (wr_s[F_CB])    pend_cb_r    <= command[7:0];
            if (wr_s[F_Y])     pend_y_r     <= command[7:0];
            if (wr_s[F_CR])    pend_cr_r    <= command[7:0];
            if (wr_s[F_SPEED]) pend_speed_r <= command[3:0];
        end
    end

    // Active set update at the frame boundary; scroll uses the speed that was active during the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r   <= MODE_FLAT;
            cb_r     <= BLANK_C;
            y_r      <= BLANK_Y;
            cr_r     <= BLANK_C;
            speed_r  <= 4'd0;
            offset_r <= 8'd0;
        end else if (frame_end) begin
            offset_r <= offset_r + {4'd0, speed_r};
            if (pend_v_r[F_MODE])  mode_r  <= pend_mode_r;
            if (pend_v_r[F_CB])    cb_r    <= pend_cb_r;
            if (pend_v_r[F_Y])     y_r     <= pend_y_r;
            if (pend_v_r[F_CR])    cr_r    <= pend_cr_r;
            if (pend_v_r[F_SPEED]) speed_r <= pend_speed_r;
        end
    end

    assign bar_s = bar_colour(pixel[BAR_SHIFT+2:BAR_SHIFT]);

    // Pattern selection from the active set as it stands this cycle; blank outside active video
    always_comb begin
        y_s  = BLANK_Y;
        cb_s = BLANK_C;
        cr_s = BLANK_C;
        if (de) begin
            case (mode_r)
                MODE_FLAT: begin
                    y_s  = y_r;
                    cb_s = cb_r;
                    cr_s = cr_r;
                end
                MODE_BARS: begin
                    y_s  = bar_s[23:16];
                    cb_s = bar_s[15:8];
                    cr_s = bar_s[7:0];
                end
                MODE_CHECKER: begin
                    if (pixel[CHECK_SHIFT] ^ line[CHECK_SHIFT]) begin
                        y_s = 8'd235;
                    end else begin
                        y_s = 8'd16;
                    end
                end
                MODE_RAMP: y_s = pixel[7:0] + offset_r;
                default:   y_s = BLANK_Y;
            endcase
        end else begin
            y_s = BLANK_Y;
        end
    end

    // Output registers: one clock of latency from de/pixel/line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out_r       <= BLANK_Y;
            cb_out_r      <= BLANK_C;
            cr_out_r      <= BLANK_C;
            cmd_pending_r <= 1'b0;
        end else begin
            y_out_r       <= y_s;
            cb_out_r      <= cb_s;
            cr_out_r      <= cr_s;
            cmd_pending_r <= |pend_v_s;
        end
    end

    assign Y           = y_out_r;
    assign Cb          = cb_out_r;
    assign Cr          = cr_out_r;
    assign cmd_pending = cmd_pending_r;

endmodule

// File: tb/tb_test_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_test_pattern_gen
//   Directed scenarios followed by a randomized run, all compared against a
//   field-array reference model of the pattern generator.
// -----------------------------------------------------------------------------
module tb_test_pattern_gen;

    localparam int BS = 7;
    localparam int CS = 5;

    logic        clk;
    logic        rst_n;
    logic        de;
    logic [11:0] pixel;
    logic [11:0] line;
    logic        frame_end;
    logic        command_strobe;
    logic [17:0] command;
    logic [7:0]  Cb;
    logic [7:0]  Y;
    logic [7:0]  Cr;
    logic        cmd_pending;

    int checks = 0;
    int errors = 0;

    // Reference model: fields 0 mode, 1 Cb, 2 Y, 3 Cr, 4 speed
    int act [5];
    int pnd [5];
    bit pv  [5];
    int offset;
    int exp_y, exp_cb, exp_cr;

    int bar_y  [8] = '{235, 210, 170, 145, 106,  81,  41,  16};
    int bar_cb [8] = '{128,  16, 166,  54, 202,  90, 240, 128};
    int bar_cr [8] = '{128, 146,  16,  34, 222, 240, 110, 128};

    test_pattern_gen #(.BAR_SHIFT(BS), .CHECK_SHIFT(CS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .de             (de),
        .pixel          (pixel),
        .line           (line),
        .frame_end      (frame_end),
        .command_strobe (command_strobe),
        .command        (command),
        .Cb             (Cb),
        .Y              (Y),
        .Cr             (Cr),
        .cmd_pending    (cmd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        act[0] = 0; act[1] = 128; act[2] = 16; act[3] = 128; act[4] = 0;
        for (int i = 0; i < 5; i++) begin
            pnd[i] = 0;
            pv[i]  = 1'b0;
        end
        offset = 0;
    endtask

    function automatic bit any_pending();
        bit r = 1'b0;
        for (int i = 0; i < 5; i++) r = r | pv[i];
        return r;
    endfunction

    // Expected colour for one input sample, from the current active model state
    task automatic model_colour(input bit d, input int px, input int ln);
        exp_y = 16; exp_cb = 128; exp_cr = 128;
        if (d) begin
            if (act[0] == 0) begin
                exp_y = act[2]; exp_cb = act[1]; exp_cr = act[3];
            end else if (act[0] == 1) begin
                exp_y  = bar_y [(px >> BS) % 8];
                exp_cb = bar_cb[(px >> BS) % 8];
                exp_cr = bar_cr[(px >> BS) % 8];
            end else if (act[0] == 2) begin
                exp_y = ((((px >> CS) ^ (ln >> CS)) % 2) == 1) ? 235 : 16;
            end else begin
                exp_y = ((px % 256) + offset) % 256;
            end
        end
    endtask

    // Frame boundary first, then the command that arrived in the same cycle
    task automatic model_update(input bit fe, input bit cs, input int cmd);
        int op, ch;
        if (fe) begin
            offset = (offset + act[4]) % 256;
            for (int i = 0; i < 5; i++) begin
                if (pv[i]) act[i] = pnd[i];
                pv[i] = 1'b0;
            end
        end
        if (cs) begin
            op = (cmd >> 16) % 4;
            ch = (cmd >> 8) % 4;
            if (op == 0) begin
                pnd[0] = cmd % 4; pv[0] = 1'b1;
            end else if (op == 1 && ch < 3) begin
                pnd[1 + ch] = cmd % 256; pv[1 + ch] = 1'b1;
            end else if (op == 2) begin
                pnd[4] = cmd % 16; pv[4] = 1'b1;
            end
        end
    endtask

    // One pixel clock: drive, clock, then compare everything against the model
    task automatic step(input bit d, input int px, input int ln, input bit fe,
                        input bit cs, input int cmd);
        de             = d;
        pixel          = px[11:0];
        line           = ln[11:0];
        frame_end      = fe;
        command_strobe = cs;
        command        = cmd[17:0];
        model_colour(d, px, ln);
        @(posedge clk);
        #1;
        model_update(fe, cs, cmd);
        chk("y",           {24'd0, Y},  exp_y);
        chk("cb",          {24'd0, Cb}, exp_cb);
        chk("cr",          {24'd0, Cr}, exp_cr);
        chk("cmd_pending", {31'd0, cmd_pending}, int'(any_pending()));
        frame_end      = 1'b0;
        command_strobe = 1'b0;
    endtask

    // Asynchronous reset between clock edges; outputs must blank immediately
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_y",       {24'd0, Y},  16);
        chk("rst_cb",      {24'd0, Cb}, 128);
        chk("rst_cr",      {24'd0, Cr}, 128);
        chk("rst_pending", {31'd0, cmd_pending}, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; de = 1'b0; pixel = 12'd0; line = 12'd0;
        frame_end = 1'b0; command_strobe = 1'b0; command = 18'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Out of reset: flat blank colour
        step(1, 1234, 56, 0, 0, 0);
        chk("flat_rst_y", {24'd0, Y}, 16);
        chk("flat_rst_cb", {24'd0, Cb}, 128);

        // BARS command held until frame_end
        step(1, 384, 0, 0, 1, 18'h00001);
        step(1, 384, 0, 0, 0, 0);
        chk("bars_pend", {31'd0, cmd_pending}, 1);
        chk("bars_pre_y", {24'd0, Y}, 16);
        step(1, 384, 0, 1, 0, 0);
        chk("bars_fe_y", {24'd0, Y}, 16);
        step(1, 384, 0, 0, 0, 0);
        chk("bars_y",  {24'd0, Y},  145);
        chk("bars_cb", {24'd0, Cb}, 54);
        chk("bars_cr", {24'd0, Cr}, 34);
        chk("bars_clr", {31'd0, cmd_pending}, 0);
        for (int b = 0; b < 8; b++) step(1, b * 128 + 5, 0, 0, 0, 0);

        // CHECKER
        step(1, 0, 0, 0, 1, 18'h00002);
        step(1, 0, 0, 1, 0, 0);
        step(1, 32, 0, 0, 0, 0);
        chk("chk_y1", {24'd0, Y}, 235);
        step(1, 32, 32, 0, 0, 0);
        chk("chk_y2", {24'd0, Y}, 16);
        step(0, 32, 0, 0, 0, 0);
        chk("chk_blank_y", {24'd0, Y}, 16);
        chk("chk_blank_cb", {24'd0, Cb}, 128);

        // COLOUR: last write wins, channel 3 ignored
        step(1, 0, 0, 0, 1, 18'h00000);
        step(1, 0, 0, 0, 1, 18'h10151);
        step(1, 0, 0, 0, 1, 18'h10160);
        step(1, 0, 0, 0, 1, 18'h10377);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("col_y",  {24'd0, Y},  8'h60);
        chk("col_cb", {24'd0, Cb}, 128);
        chk("col_cr", {24'd0, Cr}, 128);
        // Channel 3 alone must not raise cmd_pending
        step(1, 0, 0, 0, 1, 18'h10377);
        chk("ch3_pend", {31'd0, cmd_pending}, 0);
        step(1, 0, 0, 0, 1, 18'h30012);
        chk("op3_pend", {31'd0, cmd_pending}, 0);
        // Command coincident with frame_end waits one frame
        step(1, 0, 0, 1, 1, 18'h10040);
        chk("coinc_pend", {31'd0, cmd_pending}, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("coinc_cb_old", {24'd0, Cb}, 128);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("coinc_cb_new", {24'd0, Cb}, 8'h40);

        // RAMP with speed 4 over 70 frames
        step(1, 0, 0, 0, 1, 18'h00003);
        step(1, 0, 0, 0, 1, 18'h20004);
        for (int f = 0; f < 70; f++) step(1, f, 0, 1, 0, 0);
        step(1, 250, 0, 0, 0, 0);
        chk("ramp_y", {24'd0, Y}, 14);

        // Reset discards a pending MODE command
        step(1, 0, 0, 0, 1, 18'h00001);
        do_reset();
        step(1, 384, 0, 1, 0, 0);
        step(1, 384, 0, 0, 0, 0);
        chk("rst_flat_y",  {24'd0, Y},  16);
        chk("rst_flat_cb", {24'd0, Cb}, 128);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            step($urandom_range(0, 9) != 0,
                 int'($urandom_range(0, 4095)),
                 int'($urandom_range(0, 4095)),
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 18'h3FFFF)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
